// File: rtl/ins_fetch_ctrl_if.sv
// ins_fetch_ctrl_if: ROM, decoder and executor handshakes of the instruction fetch controller
interface ins_fetch_ctrl_if;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ack;
    logic        dec_valid;
    logic [7:0]  dec_opcode;
    logic        dec_ready;
    logic [1:0]  dec_len;
    logic        exec_valid;
    logic [7:0]  exec_opcode;
    logic [7:0]  exec_op1;
    logic [7:0]  exec_op2;
    logic        exec_done;
    logic        pc_load;
    logic [15:0] pc_target;
    modport master (
        output rom_rd, rom_addr, dec_valid, dec_opcode, exec_valid, exec_opcode, exec_op1, exec_op2,
        input  rom_data, rom_ack, dec_ready, dec_len, exec_done, pc_load, pc_target
    );
    modport slave (
        input  rom_rd, rom_addr, dec_valid, dec_opcode, exec_valid, exec_opcode, exec_op1, exec_op2,
        output rom_data, rom_ack, dec_ready, dec_len, exec_done, pc_load, pc_target
    );
endinterface

// File: rtl/ins_fetch_ctrl.sv
// ins_fetch_ctrl: byte-serial opcode/operand fetch FSM; define INS_FETCH_PREFETCH_EN for EXEC-time opcode prefetch
module ins_fetch_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [15:0]      pc,
    ins_fetch_ctrl_if.master bus
);
`ifdef INS_FETCH_PREFETCH_EN
    typedef enum logic [2:0] {IDLE, FETCH_OP, DECODE, FETCH_B1, FETCH_B2, EXEC, PF_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH_OP, DECODE, FETCH_B1, FETCH_B2, EXEC} state_t;
`endif
    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, pc_inc;
    logic [7:0]  opc_q, opc_d, op1_q, op1_d, op2_q, op2_d;
    logic        two_q, two_d, rd;
    assign pc_inc = pc_q + 16'd1;
`ifdef INS_FETCH_PREFETCH_EN
    logic        pf_valid_q, pf_valid_d, br_q, br_d, pf_pend;
    logic [7:0]  pf_data_q, pf_data_d;
    logic [15:0] tgt_q, tgt_d;
    assign rd      = (state_q inside {FETCH_OP, FETCH_B1, FETCH_B2, PF_WAIT}) || (state_q == EXEC && !pf_valid_q);
    assign pf_pend = state_q == EXEC && !pf_valid_q && !bus.rom_ack;
`else
    assign rd = state_q inside {FETCH_OP, FETCH_B1, FETCH_B2};
`endif
    assign bus.rom_rd      = rd;
    assign bus.rom_addr    = pc_q;
    assign bus.dec_valid   = state_q == DECODE;
    assign bus.dec_opcode  = opc_q;
    assign bus.exec_valid  = state_q == EXEC;
    assign bus.exec_opcode = opc_q;
    assign bus.exec_op1    = op1_q;
    assign bus.exec_op2    = op2_q;
    assign pc              = pc_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        two_d   = two_q;
`ifdef INS_FETCH_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_data_d  = pf_data_q;
        br_d       = br_q;
        tgt_d      = tgt_q;
`endif
        case (state_q)
            IDLE:     state_d = en ? FETCH_OP : IDLE;
            FETCH_OP: if (bus.rom_ack) begin
                opc_d   = bus.rom_data;
                pc_d    = pc_inc;
                state_d = DECODE;
            end
            // operands are cleared here so any byte not fetched is zero on EXEC entry
            DECODE:   if (bus.dec_ready) begin
                two_d   = bus.dec_len[1];
                op1_d   = 8'h00;
                op2_d   = 8'h00;
                state_d = (bus.dec_len == 2'd0) ? EXEC : FETCH_B1;
            end
            FETCH_B1: if (bus.rom_ack) begin
                op1_d   = bus.rom_data;
                pc_d    = pc_inc;
                state_d = two_q ? FETCH_B2 : EXEC;
            end
            FETCH_B2: if (bus.rom_ack) begin
                op2_d   = bus.rom_data;
                pc_d    = pc_inc;
                state_d = EXEC;
            end
            EXEC: begin
`ifdef INS_FETCH_PREFETCH_EN
                if (rd && bus.rom_ack) begin
                    pf_valid_d = 1'b1;
                    pf_data_d  = bus.rom_data;
                    pc_d       = pc_inc;
                end
                if (bus.exec_done) begin
                    br_d  = bus.pc_load;
                    tgt_d = bus.pc_target;
                    if (pf_pend) state_d = PF_WAIT;
                    else begin
                        pf_valid_d = 1'b0;
                        if (bus.pc_load) begin
                            pc_d    = bus.pc_target;
                            state_d = en ? FETCH_OP : IDLE;
                        end else if (en) begin
                            opc_d   = pf_valid_q ? pf_data_q : bus.rom_data;
                            state_d = DECODE;
                        end else begin
                            // stopping: rewind so the dropped prefetch byte is fetched again later
                            pc_d    = pf_valid_q ? pc_q - 16'd1 : pc_q;
                            state_d = IDLE;
                        end
                    end
                end
`else
                if (bus.exec_done) begin
                    pc_d    = bus.pc_load ? bus.pc_target : pc_q;
                    state_d = en ? FETCH_OP : IDLE;
                end
`endif
            end
`ifdef INS_FETCH_PREFETCH_EN
            PF_WAIT:  if (bus.rom_ack) begin
                if (br_q) begin
                    pc_d    = tgt_q;
                    state_d = en ? FETCH_OP : IDLE;
                end else if (en) begin
                    opc_d   = bus.rom_data;
                    pc_d    = pc_inc;
                    state_d = DECODE;
                end else state_d = IDLE;
            end
`endif
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= 16'h0000;
            opc_q      <= 8'h00;
            op1_q      <= 8'h00;
            op2_q      <= 8'h00;
            two_q      <= 1'b0;
`ifdef INS_FETCH_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_data_q  <= 8'h00;
            br_q       <= 1'b0;
            tgt_q      <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            opc_q      <= opc_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            two_q      <= two_d;
`ifdef INS_FETCH_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_data_q  <= pf_data_d;
            br_q       <= br_d;
            tgt_q      <= tgt_d;
`endif
        end
    end
endmodule
